muldiv_seq: RTL
===============

// Module: muldiv_seq
// PURPOSE
//  Iterative multiply/divide unit that produces the 64-bit {HI,LO} result for mult/multu/div/divu.
//  It replaces the single-cycle combinational mult/div paths. It sits between the register-file
//  read ports (rs, rt) and the HI/LO register pair.
//  A start/busy/done handshake lets the control unit stall the PC while an operation runs.
//  Radix-2: multiply by shift-add, divide by restoring division, one bit per cycle.
// PARAMETERS
//  DATA_WIDTH  32  operand width; HI/LO results are DATA_WIDTH each
// PORTS
//  CLK           in   1           clock; all state changes on rising edge
//  RST           in   1           synchronous, active-high reset
//  start         in   1           request; sampled only in IDLE or DONE
//  op            in   2           00 mult (signed), 01 multu, 10 div (signed), 11 divu
//  A             in   DATA_WIDTH  rs operand (multiplicand / dividend)
//  B             in   DATA_WIDTH  rt operand (multiplier / divisor)
//  busy          out  1           1 while in RUN; CU stalls PC
//  done          out  1           one-cycle pulse; HI_res/LO_res valid, HI/LO must load
//  HI_res        out  DATA_WIDTH  mul: product[2W-1:W]; div: remainder
//  LO_res        out  DATA_WIDTH  mul: product[W-1:0];  div: quotient
//  div_by_zero   out  1           valid with done; 1 if a div/divu had B==0
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, div_by_zero=0, HI_res=0, LO_res=0, counter=0.
//  FSM
//   IDLE -> RUN on start.
//   RUN  -> DONE after DATA_WIDTH iterations.
//   DONE -> RUN on start, otherwise DONE -> IDLE.
//  Start accept, at edge k:
//   - latch op, A and B; operands may change afterwards.
//   - signed ops latch |A| and |B| as unsigned values and record the result signs.
//   - busy=1 from cycle k+1. The counter loads DATA_WIDTH-1.
//  RUN: one iteration per cycle; counter decrements. At counter==0 the next state is DONE.
//  Latency:
//   - done=1 exactly in cycle k+1+DATA_WIDTH (33 cycles for W=32).
//   - busy=0 in the done cycle.
//  Multiply: 2W-bit accumulator, shift-add on the multiplier LSB.
//   - Signed: negate the full 2W-bit product if sign(A)^sign(B).
//  Divide: restoring division, W-bit remainder plus quotient shift register.
//   - Signed quotient is negated if sign(A)^sign(B). Signed remainder takes the sign of A.
//   - Overflow 0x80000000 / 0xFFFFFFFF (signed) yields LO=0x80000000, HI=0 by the
//     magnitude method. No special flag.
//  Div by zero (op[1]=1, B==0):
//   - Skips RUN: IDLE -> DONE directly, so done is high in cycle k+1.
//   - Result is HI_res=A, LO_res={W{1'b1}}, div_by_zero=1.
//  HI_res, LO_res and div_by_zero update only on entry to DONE. They hold until the next DONE.
//  start is ignored while busy (RUN); no queuing.
//  start in the DONE cycle is accepted (back-to-back): done drops and busy rises next cycle.
//  RST at any time, including mid-RUN:
//   - Aborts the operation. No done pulse is produced.
//   - All outputs return to their reset values on the next edge.
//  op=mult with B==0 is a normal 33-cycle multiply giving 0; div_by_zero stays 0.
// TESTING
//  1. multu 0xFFFFFFFF*0xFFFFFFFF.
//     -> done at start+33; HI=0xFFFFFFFE, LO=0x00000001; busy high cycles 1..32.
//  2. mult -3*5.
//     -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; then mult 0x80000000*0x80000000 -> HI=0x40000000, LO=0.
//  3. div -7/2.
//     -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 100/7 -> LO=14, HI=2.
//     div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
//  4. divu 100/0.
//     -> done at start+1; HI=0x64, LO=0xFFFFFFFF, div_by_zero=1.
//     A following divu 9/3 clears div_by_zero and gives LO=3, HI=0.
//  5. Pulse start again at start+5 with other operands.
//     -> ignored; first result unchanged at start+33.
//     start asserted in the done cycle -> second result at +33 more cycles.
//  6. RST asserted at start+10 for one cycle.
//     -> busy=0, HI/LO=0 next cycle, no done ever pulses.
//     A new start afterwards completes normally.

Source files
------------

// File: rtl/muldiv_seq_if.sv
// Start/busy/done handshake and operand/result bus between the control unit and the
// iterative multiply/divide unit.
interface muldiv_seq_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [1:0]            op;
    logic [DATA_WIDTH-1:0] A;
    logic [DATA_WIDTH-1:0] B;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] HI_res;
    logic [DATA_WIDTH-1:0] LO_res;
    logic                  div_by_zero;

    modport master (
        output start, op, A, B,
        input  busy, done, HI_res, LO_res, div_by_zero
    );

    modport slave (
        input  start, op, A, B,
        output busy, done, HI_res, LO_res, div_by_zero
    );
endinterface

// File: rtl/muldiv_seq.sv
// Radix-2 iterative multiply/divide producing {HI,LO} for mult/multu/div/divu.
// Works on magnitudes and applies the result signs on entry to DONE.
module muldiv_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic       CLK,
    input  logic       RST,
    muldiv_seq_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [W-1:0] neg_w(input logic [W-1:0] x);
        return {W{1'b0}} - x;
    endfunction

    function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] x);
        return {(2*W){1'b0}} - x;
    endfunction

    state_t         state_r;
    state_t         state_next_s;
    logic           accept_s;
    logic           div0_s;
    logic [CW-1:0]  cnt_r;
    logic [1:0]     op_r;
    logic           res_neg_r;
    logic           rem_neg_r;
    logic [W-1:0]   opnd_r;
    logic [2*W-1:0] acc_r;
    logic [W-1:0]   hi_r;
    logic [W-1:0]   lo_r;
    logic           dbz_r;
    logic           busy_r;
    logic           done_r;

    logic           a_neg_s;
    logic           b_neg_s;
    logic [W-1:0]   a_mag_s;
    logic [W-1:0]   b_mag_s;
    logic [W:0]     mul_sum_s;
    logic [W:0]     div_shift_s;
    logic [W:0]     div_diff_s;
    logic [2*W-1:0] step_s;
    logic [2*W-1:0] prod_s;
    logic [W-1:0]   fix_hi_s;
    logic [W-1:0]   fix_lo_s;

    // Next-state decode and start acceptance
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        div0_s       = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    accept_s     = 1'b1;
                    div0_s       = bus.op[1] && (bus.B == {W{1'b0}});
                    state_next_s = div0_s ? ST_DONE : ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == {CW{1'b0}}) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand magnitudes; unsigned ops never count as negative
    always_comb begin
        a_neg_s = bus.A[W-1] & ~bus.op[0];
        b_neg_s = bus.B[W-1] & ~bus.op[0];
        a_mag_s = a_neg_s ? neg_w(bus.A) : bus.A;
        b_mag_s = b_neg_s ? neg_w(bus.B) : bus.B;
    end

    // One iteration step and the signed fix-up of its result.
    // Multiply: acc = {partial product, multiplier}; divide: acc = {remainder, quotient}.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*W-1:W]} + (acc_r[0] ? {1'b0, opnd_r} : {(W+1){1'b0}});
        div_shift_s = {acc_r[2*W-1:W], acc_r[W-1]};
        div_diff_s  = div_shift_s - {1'b0, opnd_r};
        step_s      = {mul_sum_s, acc_r[W-1:1]};
        prod_s      = {(2*W){1'b0}};
        fix_hi_s    = {W{1'b0}};
        fix_lo_s    = {W{1'b0}};
        if (op_r[1]) begin
            if (div_diff_s[W]) begin
                step_s = {div_shift_s[W-1:0], acc_r[W-2:0], 1'b0};
            end else begin
                step_s = {div_diff_s[W-1:0], acc_r[W-2:0], 1'b1};
            end
            fix_hi_s = rem_neg_r ? neg_w(step_s[2*W-1:W]) : step_s[2*W-1:W];
            fix_lo_s = res_neg_r ? neg_w(step_s[W-1:0]) : step_s[W-1:0];
        end else begin
            prod_s   = res_neg_r ? neg_2w(step_s) : step_s;
            fix_hi_s = prod_s[2*W-1:W];
            fix_lo_s = prod_s[W-1:0];
        end
    end

    // Operand latch, iteration datapath and result registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_r     <= {CW{1'b0}};
            op_r      <= 2'b00;
            res_neg_r <= 1'b0;
            rem_neg_r <= 1'b0;
            opnd_r    <= {W{1'b0}};
            acc_r     <= {(2*W){1'b0}};
            hi_r      <= {W{1'b0}};
            lo_r      <= {W{1'b0}};
            dbz_r     <= 1'b0;
        end else if (accept_s) begin
            cnt_r     <= CW'(W - 1);
            op_r      <= bus.op;
            res_neg_r <= a_neg_s ^ b_neg_s;
            rem_neg_r <= a_neg_s;
            opnd_r    <= bus.op[1] ? b_mag_s : a_mag_s;
            acc_r     <= {{W{1'b0}}, (bus.op[1] ? a_mag_s : b_mag_s)};
            if (div0_s) begin
                hi_r  <= bus.A;
                lo_r  <= {W{1'b1}};
                dbz_r <= 1'b1;
            end else begin
                hi_r  <= hi_r;
                lo_r  <= lo_r;
                dbz_r <= dbz_r;
            end
        end else if (state_r == ST_RUN) begin
            acc_r <= step_s;
            cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
            if (cnt_r == {CW{1'b0}}) begin
                hi_r  <= fix_hi_s;
                lo_r  <= fix_lo_s;
                dbz_r <= 1'b0;
            end else begin
                hi_r  <= hi_r;
                lo_r  <= lo_r;
                dbz_r <= dbz_r;
            end
        end else begin
            acc_r <= acc_r;
            cnt_r <= cnt_r;
        end
    end

    // Registered handshake outputs, aligned with the state they describe
    always_ff @(posedge CLK) begin
        if (RST) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s == ST_RUN);
            done_r <= (state_next_s == ST_DONE);
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.HI_res      = hi_r;
    assign bus.LO_res      = lo_r;
    assign bus.div_by_zero = dbz_r;
endmodule
